turn_sequencer: RTL
===================

# turn_sequencer

Per-hand player turn controller for the BlackJack datapath. It sits on the far side of the button-input block: it drives that block's turn indicator and consumes its `o_ready`/`o_command` pair. It requests cards from the deck/dealer logic and keeps the running hand total with soft-ace handling. It reports when the player's turn ends (stand, bust, 21 or card limit) so the top-level game FSM can move on to the dealer.

## Interface

**Parameters**

- `MAX_CARDS`, default 5: hand size at which the turn ends automatically (range 2–7).
- `TIMEOUT_CYCLES`, default 500_000_000: idle cycles in WAIT_CMD before an automatic stand (only with the macro).

**Ports**

- `i_clk` input 1: system clock; everything is on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_start` input 1: one-cycle pulse that begins a new hand; honoured only in IDLE or DONE.
- `i_ready` input 1: button-input block reports that a button is pressed during our turn.
- `i_command` input `` `gameCommand ``: COMMAND_NONE / COMMAND_HIT / COMMAND_STAND from the button-input block.
- `i_cardValid` input 1: card source presents a card on `i_cardRank`.
- `i_cardRank` input 4: rank 1–13 (1 = ace, 11–13 = face).
- `o_turnIndicator` output 1: player may issue a command.
- `o_cardRequest` output 1: card wanted; held until accepted.
- `o_playerTotal` output 5: current best hand total.
- `o_cardCount` output 3: cards in hand.
- `o_bust` output 1: total > 21 at turn end.
- `o_blackjack` output 1: 21 with exactly two cards.
- `o_turnDone` output 1: level; high in DONE.
- `o_timedOut` output 1: turn ended by timeout.

## Operation

**States:** IDLE, DEAL, EVAL, WAIT_CMD, HIT_REQ, WAIT_RELEASE, DONE.

- **IDLE**
  - `i_start` → DEAL.
  - Clears the total, card count, soft-ace count and all flags.
- **DEAL / HIT_REQ**
  - `o_cardRequest` = 1.
  - A card is accepted on a cycle with `o_cardRequest & i_cardValid` and a rank of 1–13. Ranks 0, 14 and 15 are discarded; the request stays high.
  - On acceptance → EVAL.
- **Card arithmetic (on the acceptance edge)**
  - Value: ace = 11 (soft-ace count + 1), 2–10 = face value, 11–13 = 10.
  - sum = total + value, computed 6 bits wide.
  - If sum > 21 and soft-ace count > 0: subtract 10 and decrement the soft-ace count. At most one subtraction per card.
  - `o_cardCount` + 1.
- **EVAL** (`o_cardRequest` = 0)
  - count < 2 → DEAL.
  - count == 2 and total == 21 → DONE with `o_blackjack` = 1.
  - total > 21 → DONE with `o_bust` = 1.
  - total == 21 or count == `MAX_CARDS` → DONE.
  - Otherwise, if the last card came from DEAL → WAIT_CMD; if it came from HIT_REQ → WAIT_RELEASE.
- **WAIT_CMD** (`o_turnIndicator` = 1)
  - `i_ready` with COMMAND_STAND → DONE.
  - `i_ready` with COMMAND_HIT → HIT_REQ.
  - `i_ready` with COMMAND_NONE is ignored.
- **WAIT_RELEASE** (`o_turnIndicator` = 1)
  - Commands are ignored.
  - → WAIT_CMD on the first cycle with `i_ready` = 0. One held button yields exactly one hit.
- **DONE**
  - `o_turnDone` = 1; all flags and the total hold.
  - `i_start` → DEAL, with the IDLE clearing applied in the same edge.
- `i_start` in any other state is ignored.

## Timing

- **Reset:** state IDLE; every output is 0, the total is 0, the count is 0. Reset during an outstanding request drops `o_cardRequest` on the next cycle; that card is not taken.
- **Start:** `i_start` at cycle N → `o_cardRequest` = 1 at N+1.
- **Card acceptance:** handshake at cycle N → `o_playerTotal`/`o_cardCount` updated and `o_cardRequest` = 0 at N+1 (EVAL) → next state at N+2. This guarantees at least one request-low cycle between cards.
- **Command:** accepted at cycle N → `o_turnIndicator` = 0 at N+1; for a hit, `o_cardRequest` = 1 at N+1.
- **Total width:** 5 bits suffices; the maximum reachable value is 30 (20 + 10).

## Configuration

- **`TURN_TIMEOUT_EN` defined:** a 32-bit counter clears on entry to WAIT_CMD and increments every WAIT_CMD cycle. When it reaches `TIMEOUT_CYCLES − 1` → DONE with `o_timedOut` = 1, treated as a stand. A command accepted in the same cycle takes priority over the timeout.
- **`TURN_TIMEOUT_EN` undefined:** no counter is built; WAIT_CMD waits indefinitely; `o_timedOut` is tied to 0.

## Test plan

- Reset, pulse start, deliver ranks 10 then 7, issue stand → total 17, count 2, `o_turnDone` = 1, `o_bust` = 0, `o_blackjack` = 0.
- Deliver ranks 1 then 13 → total 21, `o_blackjack` = 1, DONE without `o_turnIndicator` ever rising.
- Deliver 1 and 6 (soft 17), hit with 9 → total 16 (ace demoted), WAIT_RELEASE; hit with 10 → total 26, `o_bust` = 1.
- Hold HIT with `i_ready` = 1 for 50 cycles after the first hit card → exactly one extra card request; release, then hit again → second request.
- Feed rank 15 then rank 2 while `o_cardRequest` = 1 → rank 15 ignored, rank 2 added; assert reset during a request → `o_cardRequest` = 0 the next cycle and all outputs 0.
- With `TURN_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, after 10 and 5 no command → DONE after 8 WAIT_CMD cycles with `o_timedOut` = 1 and total 15.

Source files
------------

// File: rtl/turn_sequencer.sv
// Per-hand player turn controller: requests cards, tracks the soft-ace total, runs HIT/STAND.
// Optional idle auto-stand is built only when TURN_TIMEOUT_EN is defined.
`ifndef gameCommand
`define gameCommand logic [1:0]
`endif
`ifndef COMMAND_NONE
`define COMMAND_NONE 2'd0
`endif
`ifndef COMMAND_HIT
`define COMMAND_HIT 2'd1
`endif
`ifndef COMMAND_STAND
`define COMMAND_STAND 2'd2
`endif

module turn_sequencer #(
  parameter int unsigned MAX_CARDS      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_ready,
  input  `gameCommand i_command,
  input  logic        i_cardValid,
  input  logic [3:0]  i_cardRank,
  output logic        o_turnIndicator,
  output logic        o_cardRequest,
  output logic [4:0]  o_playerTotal,
  output logic [2:0]  o_cardCount,
  output logic        o_bust,
  output logic        o_blackjack,
  output logic        o_turnDone,
  output logic        o_timedOut
);

  typedef enum logic [2:0] {
    IDLE, DEAL, EVAL, WAIT_CMD, HIT_REQ, WAIT_RELEASE, DONE
  } state_t;

  state_t      state, next_state;
  logic [2:0]  soft_aces;
  logic        from_hit;

  logic        is_ace, valid_rank, accept, clear_hand;
  logic [4:0]  card_value, adj_sum;
  logic [5:0]  raw_sum;
  logic [2:0]  soft_sum, adj_soft;
  logic        set_bust, set_blackjack, timeout_fire;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] idle_cnt;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign o_timedOut = 1'b0;
`endif

  always_comb begin
    is_ace     = (i_cardRank == 4'd1);
    valid_rank = (i_cardRank != 4'd0) && (i_cardRank <= 4'd13);
    if (is_ace)                  card_value = 5'd11;
    else if (i_cardRank >= 4'd11) card_value = 5'd10;
    else                         card_value = {1'b0, i_cardRank};

    soft_sum = soft_aces + 3'(is_ace);
    raw_sum  = {1'b0, o_playerTotal} + {1'b0, card_value};
    // At most one ace demotion per card; that keeps the total within 30.
    if ((raw_sum > 6'd21) && (soft_sum != 3'd0)) begin
      adj_sum  = 5'(raw_sum - 6'd10);
      adj_soft = soft_sum - 3'd1;
    end else begin
      adj_sum  = raw_sum[4:0];
      adj_soft = soft_sum;
    end

    accept        = ((state == DEAL) || (state == HIT_REQ)) && i_cardValid && valid_rank;
    clear_hand    = (state == IDLE) || ((state == DONE) && i_start);
    set_bust      = 1'b0;
    set_blackjack = 1'b0;
    timeout_fire  = 1'b0;
    next_state    = state;

    unique case (state)
      IDLE:    if (i_start) next_state = DEAL;
      DEAL, HIT_REQ:
        if (accept) next_state = EVAL;
      EVAL: begin
        if (o_cardCount < 3'd2) begin
          next_state = DEAL;
        end else if ((o_cardCount == 3'd2) && (o_playerTotal == 5'd21)) begin
          next_state    = DONE;
          set_blackjack = 1'b1;
        end else if (o_playerTotal > 5'd21) begin
          next_state = DONE;
          set_bust   = 1'b1;
        end else if ((o_playerTotal == 5'd21) || (o_cardCount == 3'(MAX_CARDS))) begin
          next_state = DONE;
        end else begin
          next_state = from_hit ? WAIT_RELEASE : WAIT_CMD;
        end
      end
      WAIT_CMD: begin
        if (i_ready && (i_command == `COMMAND_STAND))    next_state = DONE;
        else if (i_ready && (i_command == `COMMAND_HIT)) next_state = HIT_REQ;
`ifdef TURN_TIMEOUT_EN
        else if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          next_state   = DONE;
          timeout_fire = 1'b1;
        end
`endif
      end
      WAIT_RELEASE: if (!i_ready) next_state = WAIT_CMD;
      DONE:         if (i_start) next_state = DEAL;
      default:      next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      o_cardRequest   <= 1'b0;
      o_turnIndicator <= 1'b0;
      o_turnDone      <= 1'b0;
      o_playerTotal   <= '0;
      o_cardCount     <= '0;
      soft_aces       <= '0;
      from_hit        <= 1'b0;
      o_bust          <= 1'b0;
      o_blackjack     <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      o_timedOut      <= 1'b0;
      idle_cnt        <= '0;
`endif
    end else begin
      state           <= next_state;
      o_cardRequest   <= (next_state == DEAL) || (next_state == HIT_REQ);
      o_turnIndicator <= (next_state == WAIT_CMD) || (next_state == WAIT_RELEASE);
      o_turnDone      <= (next_state == DONE);

      if (clear_hand) begin
        o_playerTotal <= '0;
        o_cardCount   <= '0;
        soft_aces     <= '0;
        from_hit      <= 1'b0;
        o_bust        <= 1'b0;
        o_blackjack   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
        o_timedOut    <= 1'b0;
`endif
      end else begin
        if (accept) begin
          o_playerTotal <= adj_sum;
          soft_aces     <= adj_soft;
          o_cardCount   <= o_cardCount + 3'd1;
          from_hit      <= (state == HIT_REQ);
        end
        if (set_bust)      o_bust      <= 1'b1;
        if (set_blackjack) o_blackjack <= 1'b1;
`ifdef TURN_TIMEOUT_EN
        if (timeout_fire)  o_timedOut  <= 1'b1;
`endif
      end

`ifdef TURN_TIMEOUT_EN
      if ((next_state == WAIT_CMD) && (state != WAIT_CMD)) idle_cnt <= '0;
      else if (state == WAIT_CMD)                          idle_cnt <= idle_cnt + 32'd1;
`endif
    end
  end

endmodule
